// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sequencer.
package tt_pkg;

    localparam int unsigned TT_NUM_VECTORS = 8;
    localparam int unsigned TT_IDX_W       = 3;
    localparam int unsigned TT_CNT_W       = 4;
    localparam int unsigned TT_MCNT_W      = 4;

    localparam logic [TT_NUM_VECTORS-1:0] TT_EXPECTED_DEFAULT = 8'h5C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable saturating down-counter; expire flags that the current settle window is ending.
module tt_settle_timer
    import tt_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [TT_CNT_W-1:0] value,
    output logic                expire
);

    logic [TT_CNT_W-1:0] count;
    logic [TT_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (load) begin
            count_d = value;
        end else if (count != '0) begin
            count_d = count - TT_CNT_W'(1);
        end
    end

    // expire is registered against the upcoming count so SETTLE can leave on count == 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            expire <= 1'b1;
        end else begin
            count  <= count_d;
            expire <= (count_d <= TT_CNT_W'(1));
        end
    end

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps {x,y,z} through 0..7, samples F/Fn after a settle window and grades the table.
// Optional build macro TT_AUTO_REPEAT_EN restarts the sweep after every completion.
module truth_table_sequencer
    import tt_pkg::*;
#(
    parameter int unsigned                 SETTLE_CYCLES = 1,
    parameter logic [TT_NUM_VECTORS-1:0]   EXPECTED      = TT_EXPECTED_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    output logic                      x,
    output logic                      y,
    output logic                      z,
    input  logic                      f_in,
    input  logic                      fn_in,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [TT_NUM_VECTORS-1:0] table_out,
    output logic [TT_MCNT_W-1:0]      mismatch_cnt,
    output logic                      comp_err,
    output logic                      aborted
);

    localparam tt_state_e          FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    localparam logic [TT_IDX_W-1:0] LAST_IDX   = TT_IDX_W'(TT_NUM_VECTORS - 1);

    tt_state_e                 state, state_d;
    logic [TT_IDX_W-1:0]       idx, idx_d;
    logic [TT_NUM_VECTORS-1:0] table_d;
    logic [TT_MCNT_W-1:0]      mcnt_d;
    logic                      comp_d, aborted_d, pass_d, done_d, busy_d;
    logic                      load, expire;

    tt_settle_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .value  (TT_CNT_W'(SETTLE_CYCLES)),
        .expire (expire)
    );

    assign x = idx[2];
    assign y = idx[1];
    assign z = idx[0];

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        table_d   = table_out;
        mcnt_d    = mismatch_cnt;
        comp_d    = comp_err;
        aborted_d = aborted;
        pass_d    = pass;
        done_d    = 1'b0;
        load      = 1'b0;

        unique case (state)
            IDLE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else if (start) begin
                    table_d   = '0;
                    mcnt_d    = '0;
                    comp_d    = 1'b0;
                    aborted_d = 1'b0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    load      = 1'b1;
                    state_d   = FIRST_STATE;
                end
            end
            SETTLE: begin
                if (expire) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // at most one increment per vector, so the count tops out at 8
                table_d[idx] = f_in;
                if (f_in != EXPECTED[idx]) begin
                    mcnt_d = mismatch_cnt + TT_MCNT_W'(1);
                end
                if (fn_in == f_in) begin
                    comp_d = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx + TT_IDX_W'(1);
                    load    = 1'b1;
                    state_d = FIRST_STATE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                pass_d = (mismatch_cnt == '0) && !comp_err;
`ifdef TT_AUTO_REPEAT_EN
                table_d   = '0;
                mcnt_d    = '0;
                comp_d    = 1'b0;
                aborted_d = 1'b0;
                idx_d     = '0;
                load      = 1'b1;
                state_d   = FIRST_STATE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        // abort overrides everything in flight but keeps the partial results
        if (abort && (state != IDLE)) begin
            state_d   = IDLE;
            idx_d     = '0;
            table_d   = table_out;
            mcnt_d    = mismatch_cnt;
            comp_d    = comp_err;
            aborted_d = 1'b1;
            pass_d    = 1'b0;
            done_d    = 1'b0;
            load      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            comp_err     <= 1'b0;
            aborted      <= 1'b0;
            pass         <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            table_out    <= table_d;
            mismatch_cnt <= mcnt_d;
            comp_err     <= comp_d;
            aborted      <= aborted_d;
            pass         <= pass_d;
            done         <= done_d;
            busy         <= busy_d;
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Randomized bench for truth_table_sequencer against a cycle-level behavioural model.
module tb_truth_table_sequencer;

    localparam int unsigned S     = 1;
    localparam int unsigned PER   = S + 1;
    localparam int unsigned TOTAL = 8 * PER + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort, f_in, fn_in;
    logic       x, y, z, busy, done, pass, comp_err, aborted;
    logic [7:0] table_out;
    logic [3:0] mismatch_cnt;

    logic [7:0] ftab, cmask;
    logic       start0, f0, fn0, x0, y0, z0, busy0, done0, pass0, comp0, ab0;
    logic [7:0] table0;
    logic [3:0] mcnt0;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    truth_table_sequencer #(.SETTLE_CYCLES(S), .EXPECTED(8'h5C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x(x), .y(y), .z(z), .f_in(f_in), .fn_in(fn_in),
        .busy(busy), .done(done), .pass(pass), .table_out(table_out),
        .mismatch_cnt(mismatch_cnt), .comp_err(comp_err), .aborted(aborted)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(0), .EXPECTED(8'h5C)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
        .x(x0), .y(y0), .z(z0), .f_in(f0), .fn_in(fn0),
        .busy(busy0), .done(done0), .pass(pass0), .table_out(table0),
        .mismatch_cnt(mcnt0), .comp_err(comp0), .aborted(ab0)
    );

    // evaluator for the main DUT: F from ftab, Fn forced equal to F where cmask is set
    always_comb begin
        f_in  = ftab[{x, y, z}];
        fn_in = cmask[{x, y, z}] ? f_in : ~f_in;
    end

    // golden evaluator for the zero-settle instance
    always_comb begin
        f0  = (x0 & ~z0) | (~x0 & y0);
        fn0 = ~f0;
    end

    function automatic logic [7:0] golden_tab();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v    = 3'(i);
            t[i] = (v[2] & ~v[0]) | (~v[2] & v[1]);
        end
        return t;
    endfunction

    function automatic logic [7:0] low_mask(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (i < n);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural model: position in the sweep (t cycles since start) defines every output
    bit         run;
    int         t, n;
    logic [7:0] e_tab;
    logic [3:0] e_m;
    logic [2:0] e_xyz;
    logic       e_comp, e_ab, e_pass, e_done, e_busy;

    always @(posedge clk) begin
        logic st, ab;
        st = start;
        ab = abort;
        if (!rst_n) begin
            run = 0; t = 0; n = 0;
            e_tab = '0; e_m = '0; e_xyz = '0;
            e_comp = 0; e_ab = 0; e_pass = 0; e_done = 0; e_busy = 0;
        end else begin
            e_done = 0;
            if (run) begin
                if (ab) begin
                    run = 0; e_busy = 0; e_xyz = '0; e_ab = 1; e_pass = 0;
                end else begin
                    t++;
                    n      = (t / PER > 8) ? 8 : t / PER;
                    e_tab  = ftab & low_mask(n);
                    e_m    = 4'($countones((ftab ^ 8'h5C) & low_mask(n)));
                    e_comp = |(cmask & low_mask(n));
                    e_xyz  = 3'((t / PER > 7) ? 7 : t / PER);
                    if (t == TOTAL) begin
                        run = 0; e_busy = 0; e_done = 1;
                        e_pass = (e_m == 0) && !e_comp;
                    end
                end
            end else if (ab) begin
                e_ab = 1;
            end else if (st) begin
                run = 1; t = 0; e_busy = 1; e_xyz = '0;
                e_tab = '0; e_m = '0; e_comp = 0; e_ab = 0; e_pass = 0;
            end
        end
        #1;
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("pass", pass, e_pass);
        chk("xyz", {x, y, z}, e_xyz);
        chk("table_out", table_out, e_tab);
        chk("mismatch_cnt", mismatch_cnt, e_m);
        chk("comp_err", comp_err, e_comp);
        chk("aborted", aborted, e_ab);
    end

    task automatic pulse_start(output int k);
        start = 1'b1;
        @(negedge clk);
        k     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int when);
        when = -1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
        if (when < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int k, when;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0;
        ftab  = golden_tab(); cmask = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // golden sweep, start sampled at edge 10
        while (cyc < 9) @(negedge clk);
        pulse_start(k);
        chk("t1_start_edge", k, 10);
        wait_done(40, when);
        chk("t1_latency", when, 27);
        chk("t1_table", table_out, 8'h5C);
        chk("t1_mcnt", mismatch_cnt, 0);
        chk("t1_pass", pass, 1);
        chk("t1_comp", comp_err, 0);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);

        // F stuck at 0
        ftab = 8'h00;
        pulse_start(k);
        wait_done(40, when);
        chk("t2_table", table_out, 8'h00);
        chk("t2_mcnt", mismatch_cnt, 4);
        chk("t2_pass", pass, 0);
        chk("t2_comp", comp_err, 0);
        repeat (2) @(negedge clk);

        // Fn equals F at vector 3 only
        ftab = golden_tab(); cmask = 8'h08;
        pulse_start(k);
        wait_done(40, when);
        chk("t3_comp", comp_err, 1);
        chk("t3_pass", pass, 0);
        chk("t3_table", table_out, 8'h5C);
        repeat (2) @(negedge clk);

        // abort sampled 5 edges after start
        cmask = 8'h00;
        pulse_start(k);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_done", done, 0);
        chk("t4_aborted", aborted, 1);
        chk("t4_xyz", {x, y, z}, 0);
        chk("t4_table", table_out, 8'h00);
        repeat (20) begin
            @(negedge clk);
            if (done) chk("t4_no_done", done, 0);
        end

        // start re-pulsed mid-sweep leaves timing untouched
        pulse_start(k);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, when);
        chk("t5_latency", when - k, 17);
        repeat (2) @(negedge clk);

        // reset asserted mid-sweep
        pulse_start(k);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_xyz", {x, y, z}, 0);
        chk("t5_rst_table", table_out, 0);
        chk("t5_rst_mcnt", mismatch_cnt, 0);
        chk("t5_rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // randomized sweeps with optional abort and stray starts
        for (int s = 0; s < 30; s++) begin
            bit do_ab;
            int at;
            ftab  = 8'($urandom);
            cmask = ($urandom_range(0, 1) == 1) ? (8'($urandom) & 8'($urandom)) : 8'h00;
            do_ab = ($urandom_range(0, 3) == 0);
            at    = $urandom_range(1, 17);
            pulse_start(k);
            for (int c = 1; c <= 20; c++) begin
                abort = do_ab && (c == at);
                start = (c <= 16) && (!do_ab || c < at) && ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            start = 1'b0; abort = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; abort = 1'b1;
                @(negedge clk);
                start = 1'b0; abort = 1'b0;
            end
            @(negedge clk);
        end

        // zero settle: one vector per cycle
        start0 = 1'b1;
        @(negedge clk);
        k      = cyc;
        start0 = 1'b0;
        when   = -1;
        for (int i = 0; i < 30; i++) begin
            if (done0) begin
                when = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("t6_latency", when - k, 9);
        chk("t6_table", table0, 8'h5C);
        chk("t6_pass", pass0, 1);
        chk("t6_mcnt", mcnt0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
